// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the clock time-setting controller.
//   state_t      : controller states RUN / SET_HRS / SET_MIN / COMMIT
//   FIELD_*      : edit_field encodings presented to the display
//   *_MAX_BCD    : highest legal BCD value for hours and minutes
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HRS = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_HRS  = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;

  localparam logic [7:0] HRS_MAX_BCD = 8'h23;
  localparam logic [7:0] MIN_MAX_BCD = 8'h59;

endpackage

// File: rtl/bcd2_wrap_inc.sv
// Two-digit BCD incrementer with wrap.
//   MAX_BCD  : largest legal value; incrementing it yields 8'h00
//   bcd_in   : current value (tens in [7:4], ones in [3:0])
//   bcd_next : incremented value; any malformed or out-of-range input
//              yields 8'h00 so a bad captured value self-heals on first edit
module bcd2_wrap_inc
  import clk_ctrl_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = MIN_MAX_BCD
) (
  input  logic [7:0] bcd_in,
  output logic [7:0] bcd_next
);

  logic [3:0] tens;
  logic [3:0] ones;
  logic       invalid;

  always_comb begin
    tens     = bcd_in[7:4];
    ones     = bcd_in[3:0];
    // With both digits legal, binary magnitude order equals BCD order.
    invalid  = (tens > 4'd9) || (ones > 4'd9) || (bcd_in > MAX_BCD);
    bcd_next = '0;
    if (invalid || (bcd_in == MAX_BCD)) begin
      bcd_next = '0;
    end else if (ones == 4'd9) begin
      bcd_next = {tens + 4'd1, 4'd0};
    end else begin
      bcd_next = {tens, ones + 4'd1};
    end
  end

endmodule

// File: rtl/clk_set_ctrl.sv
// Time-setting controller for the hh:mm:ss clock datapath.
//   clk, reset          : single clock, synchronous active-high reset
//   mode_btn, inc_btn   : debounced button levels (edge-detected here)
//   cur_hrs_bcd/min_bcd : live datapath time, captured on entering edit
//   run_en              : 1 lets the datapath count, 0 freezes it
//   load                : one-cycle commit strobe for set_hrs/set_min
//   set_hrs/min_bcd     : edit registers, always visible
//   edit_field          : 00 none, 01 hours, 10 minutes
//   blink               : blanking toggle for the field under edit
// All outputs come straight from flops: next values are computed
// combinationally and registered together with the state.
module clk_set_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 8,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [7:0] cur_hrs_bcd,
  input  logic [7:0] cur_min_bcd,
  output logic       run_en,
  output logic       load,
  output logic [7:0] set_hrs_bcd,
  output logic [7:0] set_min_bcd,
  output logic [1:0] edit_field,
  output logic       blink
);

  localparam int unsigned IW = $clog2(TIMEOUT);
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_t        state_q, state_d;
  logic          mode_q, inc_q;
  logic          mode_rise, inc_rise;
  logic [IW-1:0] idle_q, idle_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_d;
  logic [7:0]    hrs_d, min_d;
  logic [7:0]    hrs_inc, min_inc;
  logic          run_en_d, load_d;
  logic [1:0]    edit_field_d;
  logic          in_edit_d;

  bcd2_wrap_inc #(.MAX_BCD(HRS_MAX_BCD)) u_hrs_inc (
    .bcd_in   (set_hrs_bcd),
    .bcd_next (hrs_inc)
  );

  bcd2_wrap_inc #(.MAX_BCD(MIN_MAX_BCD)) u_min_inc (
    .bcd_in   (set_min_bcd),
    .bcd_next (min_inc)
  );

  assign mode_rise = mode_btn & ~mode_q;
  assign inc_rise  = inc_btn & ~inc_q;

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    bcnt_d  = bcnt_q;
    blink_d = 1'b0;
    hrs_d   = set_hrs_bcd;
    min_d   = set_min_bcd;

    case (state_q)
      RUN: begin
        if (mode_rise) begin
          state_d = SET_HRS;
          hrs_d   = cur_hrs_bcd;
          min_d   = cur_min_bcd;
          idle_d  = '0;
          bcnt_d  = '0;
        end
      end
      SET_HRS, SET_MIN: begin
        // Blink phase runs freely across both edit fields.
        if (bcnt_q == BW'(BLINK_DIV - 1)) begin
          bcnt_d  = '0;
          blink_d = ~blink;
        end else begin
          bcnt_d  = bcnt_q + 1'b1;
          blink_d = blink;
        end
        // Mode outranks increment; any activity outranks the timeout.
        if (mode_rise) begin
          state_d = (state_q == SET_HRS) ? SET_MIN : COMMIT;
          idle_d  = '0;
        end else if (inc_rise) begin
          if (state_q == SET_HRS) hrs_d = hrs_inc;
          else                    min_d = min_inc;
          idle_d = '0;
        end else if (idle_q == IW'(TIMEOUT - 1)) begin
          state_d = RUN;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      COMMIT:  state_d = RUN;
      default: state_d = RUN;
    endcase

    in_edit_d    = (state_d == SET_HRS) || (state_d == SET_MIN);
    blink_d      = blink_d & in_edit_d;
    run_en_d     = (state_d == RUN);
    load_d       = (state_d == COMMIT);
    edit_field_d = (state_d == SET_HRS) ? FIELD_HRS :
                   (state_d == SET_MIN) ? FIELD_MIN : FIELD_NONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      mode_q      <= 1'b0;
      inc_q       <= 1'b0;
      idle_q      <= '0;
      bcnt_q      <= '0;
      blink       <= 1'b0;
      set_hrs_bcd <= '0;
      set_min_bcd <= '0;
      run_en      <= 1'b1;
      load        <= 1'b0;
      edit_field  <= FIELD_NONE;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_btn;
      inc_q       <= inc_btn;
      idle_q      <= idle_d;
      bcnt_q      <= bcnt_d;
      blink       <= blink_d;
      set_hrs_bcd <= hrs_d;
      set_min_bcd <= min_d;
      run_en      <= run_en_d;
      load        <= load_d;
      edit_field  <= edit_field_d;
    end
  end

endmodule

// File: tb/tb_clk_set_ctrl.sv
// Bench for clk_set_ctrl: directed button sequences, a behavioural model
// of the edit session checked against the DUT on every falling edge, and
// hand-computed literal expectations at key points.
module tb_clk_set_ctrl;

  localparam int unsigned BD = 8;
  localparam int unsigned TO = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [7:0] cur_hrs_bcd = 8'h12;
  logic [7:0] cur_min_bcd = 8'h34;
  logic       run_en, load, blink;
  logic [7:0] set_hrs_bcd, set_min_bcd;
  logic [1:0] edit_field;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          chk_en   = 1'b0;
  int unsigned load_hits = 0;

  clk_set_ctrl #(.BLINK_DIV(BD), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .mode_btn    (mode_btn),
    .inc_btn     (inc_btn),
    .cur_hrs_bcd (cur_hrs_bcd),
    .cur_min_bcd (cur_min_bcd),
    .run_en      (run_en),
    .load        (load),
    .set_hrs_bcd (set_hrs_bcd),
    .set_min_bcd (set_min_bcd),
    .edit_field  (edit_field),
    .blink       (blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal view of a BCD value; out-of-range or malformed -> 0.
  function automatic logic [7:0] model_inc(input logic [7:0] v, input int unsigned maxv);
    int unsigned t, o, n;
    t = v[7:4];
    o = v[3:0];
    n = t * 10 + o;
    if (t > 9 || o > 9 || n > maxv) return 8'h00;
    n = (n + 1) % (maxv + 1);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  // Model: 0 running, 1 editing hours, 2 editing minutes, 3 committing.
  int unsigned m_st, m_idle, m_age;
  logic [7:0]  m_hrs, m_min;
  bit          m_mprev, m_iprev;

  always @(posedge clk) begin
    bit mr, ir;
    if (reset) begin
      m_st = 0; m_idle = 0; m_age = 0;
      m_hrs = 8'h00; m_min = 8'h00;
      m_mprev = 0; m_iprev = 0;
    end else begin
      mr = mode_btn && !m_mprev;
      ir = inc_btn && !m_iprev;
      case (m_st)
        0: if (mr) begin
             m_st = 1; m_hrs = cur_hrs_bcd; m_min = cur_min_bcd;
             m_idle = 0; m_age = 0;
           end
        1, 2: begin
          m_age++;
          if (mr) begin
            m_st = m_st + 1; m_idle = 0;
          end else if (ir) begin
            if (m_st == 1) m_hrs = model_inc(m_hrs, 23);
            else           m_min = model_inc(m_min, 59);
            m_idle = 0;
          end else if (m_idle + 1 >= TO) begin
            m_st = 0;
          end else begin
            m_idle++;
          end
        end
        default: m_st = 0;
      endcase
      m_mprev = mode_btn;
      m_iprev = inc_btn;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model run_en", {7'b0, run_en}, {7'b0, (m_st == 0)});
      chk("model load", {7'b0, load}, {7'b0, (m_st == 3)});
      chk("model edit_field", {6'b0, edit_field},
          (m_st == 1) ? 8'd1 : (m_st == 2) ? 8'd2 : 8'd0);
      chk("model set_hrs", set_hrs_bcd, m_hrs);
      chk("model set_min", set_min_bcd, m_min);
      chk("model blink", {7'b0, blink},
          (m_st == 1 || m_st == 2) ? 8'((m_age / BD) % 2) : 8'd0);
    end
    if (load) load_hits++;
  end

  task automatic press(input logic m, input logic i, input int unsigned hold);
    @(negedge clk);
    mode_btn = m;
    inc_btn  = i;
    repeat (hold) @(negedge clk);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst run_en", {7'b0, run_en}, 8'd1);
    chk("rst load", {7'b0, load}, 8'd0);
    chk("rst set_hrs", set_hrs_bcd, 8'h00);
    chk("rst set_min", set_min_bcd, 8'h00);
    chk("rst edit_field", {6'b0, edit_field}, 8'd0);
    chk("rst blink", {7'b0, blink}, 8'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Capture 12:34 and edit hours
    press(1'b1, 1'b0, 1);
    chk("cap edit_field", {6'b0, edit_field}, 8'd1);
    chk("cap run_en", {7'b0, run_en}, 8'd0);
    chk("cap set_hrs", set_hrs_bcd, 8'h12);
    chk("cap set_min", set_min_bcd, 8'h34);
    chk("cap load", {7'b0, load}, 8'd0);
    for (int k = 0; k < 11; k++) press(1'b0, 1'b1, 1);
    chk("hrs reach 23", set_hrs_bcd, 8'h23);
    press(1'b0, 1'b1, 1);
    chk("hrs wrap 00", set_hrs_bcd, 8'h00);
    press(1'b0, 1'b1, 10);
    chk("held inc once", set_hrs_bcd, 8'h01);

    // Minutes then commit
    press(1'b1, 1'b0, 1);
    chk("setmin field", {6'b0, edit_field}, 8'd2);
    press(1'b1, 1'b0, 1);
    chk("commit load", {7'b0, load}, 8'd1);
    chk("commit hrs", set_hrs_bcd, 8'h01);
    chk("commit min", set_min_bcd, 8'h34);
    chk("commit run_en", {7'b0, run_en}, 8'd0);
    @(negedge clk);
    chk("post commit load", {7'b0, load}, 8'd0);
    chk("post commit run_en", {7'b0, run_en}, 8'd1);
    chk("post commit field", {6'b0, edit_field}, 8'd0);
    chk("post commit blink", {7'b0, blink}, 8'd0);

    // Invalid hours capture, minute wrap, simultaneous rises
    cur_hrs_bcd = 8'h2A;
    cur_min_bcd = 8'h58;
    press(1'b1, 1'b0, 1);
    chk("cap bad hrs", set_hrs_bcd, 8'h2A);
    press(1'b0, 1'b1, 1);
    chk("bad hrs inc", set_hrs_bcd, 8'h00);
    press(1'b1, 1'b0, 1);
    press(1'b0, 1'b1, 1);
    chk("min 59", set_min_bcd, 8'h59);
    press(1'b0, 1'b1, 1);
    chk("min wrap 00", set_min_bcd, 8'h00);
    chk("hrs kept", set_hrs_bcd, 8'h00);
    press(1'b1, 1'b1, 1);
    chk("both load", {7'b0, load}, 8'd1);
    chk("both min kept", set_min_bcd, 8'h00);
    @(negedge clk);
    chk("both back run", {7'b0, run_en}, 8'd1);

    // Blink cadence and idle timeout
    cur_hrs_bcd = 8'h09;
    cur_min_bcd = 8'h15;
    load_hits   = 0;
    press(1'b1, 1'b0, 1);
    chk("blink entry", {7'b0, blink}, 8'd0);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 7)  chk("blink 7", {7'b0, blink}, 8'd0);
      if (k == 8)  chk("blink 8", {7'b0, blink}, 8'd1);
      if (k == 15) chk("blink 15", {7'b0, blink}, 8'd1);
      if (k == 16) chk("blink 16", {7'b0, blink}, 8'd0);
      if (k == 23) chk("blink 23", {7'b0, blink}, 8'd0);
      if (k == 24) chk("blink 24", {7'b0, blink}, 8'd1);
    end
    press(1'b0, 1'b1, 1);
    chk("to inc", set_hrs_bcd, 8'h10);
    repeat (TO - 1) @(negedge clk);
    chk("to not yet", {6'b0, edit_field}, 8'd1);
    @(negedge clk);
    chk("to run_en", {7'b0, run_en}, 8'd1);
    chk("to field", {6'b0, edit_field}, 8'd0);
    chk("to hrs kept", set_hrs_bcd, 8'h10);
    chk("to no load", 8'(load_hits), 8'd0);

    // Reset mid-edit
    press(1'b1, 1'b0, 1);
    press(1'b1, 1'b0, 1);
    chk("pre rst field", {6'b0, edit_field}, 8'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid rst run_en", {7'b0, run_en}, 8'd1);
    chk("mid rst load", {7'b0, load}, 8'd0);
    chk("mid rst hrs", set_hrs_bcd, 8'h00);
    chk("mid rst min", set_min_bcd, 8'h00);
    chk("mid rst field", {6'b0, edit_field}, 8'd0);
    chk("mid rst blink", {7'b0, blink}, 8'd0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
